// File: rtl/vector_serializer.sv
// vector_serializer
//   Parallel-to-serial source: accepts a packed vector of N signed WIDTH-bit
//   elements on a valid/ready load port and emits one element per cycle on a
//   valid/ready output stream, flagging the final element with out_last.
//
//   Build option: VECTOR_SERIALIZER_REVERSE_EN
//     defined     -> elements emitted N-1 down to 0, out_last at index 0
//     not defined -> elements emitted 0 up to N-1, out_last at index N-1
//
//   Ports
//     clk        in   rising-edge clock
//     rst        in   synchronous active-high reset
//     load_valid in   load_data is valid
//     load_ready out  vector accepted this cycle (combinational from out_ready)
//     load_data  in   packed vector, element i at [i*WIDTH +: WIDTH]
//     out_valid  out  out_data is valid
//     out_ready  in   consumer accepts the current element
//     out_data   out  current element (signed, passed through unmodified)
//     out_last   out  current element is the last of the vector
//     busy       out  a vector is held (STREAM state)
module vector_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [N*WIDTH-1:0]      load_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_data,
   output logic                    out_last,
   output logic                    busy
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

`ifdef VECTOR_SERIALIZER_REVERSE_EN
   localparam logic [IW-1:0] FIRST_IDX = IW'(N - 1);
   localparam logic [IW-1:0] LAST_IDX  = '0;
`else
   localparam logic [IW-1:0] FIRST_IDX = '0;
   localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
`endif

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [N*WIDTH-1:0]        buf_q, buf_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic                      out_valid_q, out_valid_d;
   logic                      out_last_q, out_last_d;
   logic signed [WIDTH-1:0]   out_data_q, out_data_d;
   logic [IW-1:0]             idx_nxt;

   function automatic logic [WIDTH-1:0] elem(input logic [N*WIDTH-1:0] v,
                                             input logic [IW-1:0]      i);
      return v[i*WIDTH +: WIDTH];
   endfunction

`ifdef VECTOR_SERIALIZER_REVERSE_EN
   assign idx_nxt = idx_q - 1'b1;
`else
   assign idx_nxt = idx_q + 1'b1;
`endif

   // Outputs are registered one cycle ahead: the element that will be shown
   // next is selected here, so out_data never changes during a stall.
   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      unique case (state_q)
         IDLE: begin
            if (load_valid) begin
               state_d     = STREAM;
               buf_d       = load_data;
               idx_d       = FIRST_IDX;
               out_valid_d = 1'b1;
               out_data_d  = elem(load_data, FIRST_IDX);
               out_last_d  = (FIRST_IDX == LAST_IDX);
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (!out_last_q) begin
                  idx_d      = idx_nxt;
                  out_data_d = elem(buf_q, idx_nxt);
                  out_last_d = (idx_nxt == LAST_IDX);
               end else if (load_valid) begin
                  // Last beat accepted with a vector waiting: restart without a bubble.
                  buf_d       = load_data;
                  idx_d       = FIRST_IDX;
                  out_valid_d = 1'b1;
                  out_data_d  = elem(load_data, FIRST_IDX);
                  out_last_d  = (FIRST_IDX == LAST_IDX);
               end else begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         buf_q       <= '0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
      end
   end

   // Same-cycle path from out_ready lets a new vector follow the last beat directly.
   assign load_ready = (state_q == IDLE) | ((state_q == STREAM) & out_last_q & out_ready);
   assign busy       = (state_q == STREAM);
   assign out_valid  = out_valid_q;
   assign out_last   = out_last_q;
   assign out_data   = out_data_q;

endmodule

// File: doc/vector_serializer.md
# vector_serializer

Parallel-to-serial source for the streaming arithmetic units. Accepts a packed vector of `N` signed `WIDTH`-bit elements through a valid/ready load handshake. Emits the elements one per cycle on a valid/ready output stream with an end-of-vector flag. The output `out_valid`/`out_data` pair drives the `enable`/`in` inputs of the serial reduction blocks (running max, etc.); `out_last` marks where a downstream accumulator's result is final.

## Interface
- `WIDTH`, 8, element width in bits; elements are two's complement.
- `N`, 4, elements per vector; must be ≥ 1.
- `clk` input 1, rising-edge clock.
- `rst` input 1, reset; synchronous, active-high.
- `load_valid` input 1, `load_data` is valid.
- `load_ready` output 1, block accepts a vector this cycle.
- `load_data` input N*WIDTH, packed vector; element i is bits `[i*WIDTH +: WIDTH]`.
- `out_valid` output 1, `out_data` is valid; connects to a reduction unit's `enable`.
- `out_ready` input 1, consumer accepts the current element; tie to 1 for free-running consumers.
- `out_data` output WIDTH signed, current element.
- `out_last` output 1, current element is the final element of the vector.
- `busy` output 1, a vector is held (state STREAM).

## Operation
- FSM with two states: IDLE and STREAM. A buffer register holds N*WIDTH bits. An index counter is `$clog2(N)` bits wide, minimum 1.
- **IDLE**
  - `load_ready`=1, `out_valid`=0.
  - On `load_valid`: capture `load_data` into the buffer, set index to the first element, go to STREAM.
- **STREAM**
  - `out_valid`=1, `out_data`=buffer[index], `out_last`=(index is the final position).
  - On `out_ready`, when the element is not last: advance the index.
  - On `out_ready`, when the element is last:
    - If `load_valid`, capture the new vector and restart the index. The state stays STREAM, so there is no bubble.
    - Otherwise go to IDLE.
  - When `out_ready`=0, all outputs hold unchanged. `out_data` must not change while `out_valid`=1 and the beat has not been accepted.
- `load_ready` = IDLE | (STREAM & `out_last` & `out_ready`). This is a combinational path from `out_ready` to `load_ready`, and it is intentional.
- Data passes through unmodified: no sign extension, no saturation. The most negative value (−2^(WIDTH−1)) must survive intact.
- N=1: every beat has `out_last`=1.
- A load is ignored whenever `load_ready`=0. The upstream producer must hold `load_valid`/`load_data` until accepted.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_last`=0, `out_data`=0, `busy`=0, index=0, buffer=0, `load_ready`=1 in the cycle after reset.
- If the load is accepted at edge t, the first element is valid in cycle t+1.
- With `out_ready` held at 1, a vector streams in exactly N consecutive cycles.
- Back-to-back vectors with `load_valid` held and `out_ready`=1 give continuous output with no idle cycle. Throughput is 1 element/cycle.
- After the last beat is accepted with no pending load, `out_valid`=0 in the next cycle.
- `rst` mid-stream abandons the vector. On the next cycle the block is in IDLE with the reset values and no partial beat is emitted. `rst` has priority over a simultaneous load.

## Configuration
- Macro `VECTOR_SERIALIZER_REVERSE_EN`.
- **Defined**: elements are emitted from index N−1 down to 0. The index starts at N−1 and decrements, and `out_last` is asserted at index 0.
- **Not defined**: elements are emitted in ascending order 0 to N−1, and `out_last` is asserted at index N−1.
- All handshake and timing rules are identical in both builds.

## Test plan
Use WIDTH=8, N=4 unless stated.
- **Basic stream**: reset, then load elements {0:5, 1:−3, 2:127, 3:−128} with `out_ready`=1.
  - Outputs are 5, −3, 127, −128 on cycles t+1..t+4.
  - `out_last` only on −128.
  - Feeding these into a serial max unit gives a max of 127.
- **Backpressure**: same vector, `out_ready` toggling 1,0,0,1,1,0,1. Each element is held stable while stalled, and exactly 4 beats are accepted in order.
- **Back-to-back**: two vectors presented consecutively with `load_valid` held. There are 8 contiguous valid beats with no gap, and `out_last` is high on beats 4 and 8. `load_ready` pulses only on beat 4.
- **Reset mid-stream**: assert `rst` after 2 accepted beats.
  - Next cycle: `out_valid`=0, `busy`=0, `load_ready`=1.
  - A new vector {1,2,3,4} then streams starting at 1.
- **N=1 and reverse build**:
  - N=1, load −128: a single beat of −128 with `out_last`=1.
  - With `VECTOR_SERIALIZER_REVERSE_EN`, N=4, vector {0:5, 1:−3, 2:127, 3:−128}: output order is −128, 127, −3, 5, with `out_last` on 5.
